shift_add_multiplier: RTL and testbench

Multi-cycle unsigned multiplier using shift-and-add, the arithmetic inverse of the team's repeated-subtraction divider. It accepts two DATA_WIDTH operands on a start pulse and iterates one multiplier bit per clock. It returns an exact 2*DATA_WIDTH product with a one-cycle done pulse. It sits beside the divider in the arithmetic block set, for datapaths that trade latency for area.

---
 rtl/shift_add_multiplier.sv | 107 ++++++++++
 tb/tb_shift_add_multiplier.sv | 125 ++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier.
// Each RUN cycle consumes one multiplier bit, so a result takes DataWidth cycles after start.
//
// Ports:
//   clk_i           rising-edge clock
//   rst_i           asynchronous active-high reset
//   start_i         begin a multiplication (sampled only when idle)
//   multiplicand_i  operand A, latched with start_i
//   multiplier_i    operand B, latched with start_i
//   product_o       registered 2*DataWidth result of the last completed operation
//   busy_o          high while iterating
//   done_o          one-cycle pulse when product_o has just been updated
module shift_add_multiplier #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [DataWidth-1:0]     multiplicand_i,
  input  logic [DataWidth-1:0]     multiplier_i,
  output logic [2*DataWidth-1:0]   product_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DataWidth - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q, state_d;
  logic [DataWidth-1:0]     mcand_q, mcand_d;
  logic [DataWidth-1:0]     mplier_q, mplier_d;
  logic [DataWidth:0]       hi_q, hi_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [2*DataWidth-1:0]   product_q, product_d;

  logic [DataWidth:0]       addend;
  logic [DataWidth:0]       sum;

  // hi_q never exceeds 2^DataWidth-1 after a shift, so the sum fits in DataWidth+1 bits.
  always_comb begin
    addend = mplier_q[0] ? {1'b0, mcand_q} : '0;
    sum    = hi_q + addend;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mcand_d  = multiplicand_i;
          mplier_d = multiplier_i;
          hi_d     = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // Shift {sum, mplier} right by one: low product bits migrate into mplier_q.
        hi_d     = {1'b0, sum[DataWidth:1]};
        mplier_d = {sum[0], mplier_q[DataWidth-1:1]};
        if (cnt_q == LastCnt) begin
          product_d = {sum, mplier_q[DataWidth-1:1]};
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;
  assign busy_o    = (state_q == StRun);
  assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  localparam int unsigned W = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [W-1:0]     multiplicand_i = '0;
  logic [W-1:0]     multiplier_i = '0;
  logic [2*W-1:0]   product_o;
  logic             busy_o;
  logic             done_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [2*W-1:0] last_prod = '0;

  shift_add_multiplier #(.DataWidth(W)) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .product_o      (product_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; the start is sampled on the next rising edge.
  // While running, start and operand pins are scrambled to prove they are ignored.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [2*W-1:0] exp;
    int bad;
    exp = (2*W)'(int'(a) * int'(b));
    start_i = 1'b1;
    multiplicand_i = a;
    multiplier_i = b;
    @(negedge clk_i);  // after e0
    bad = 0;
    for (int i = 0; i < int'(W); i++) begin
      if (busy_o !== 1'b1 || done_o !== 1'b0 || product_o !== last_prod) bad++;
      start_i = 1'($urandom);
      multiplicand_i = W'($urandom);
      multiplier_i = W'($urandom);
      @(negedge clk_i);
    end
    // Now after eN: done cycle; keep pushing start, it must be ignored.
    check({tag, "_run"}, 64'(bad), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_busy_in_done"}, 64'(busy_o), 64'd0);
    check({tag, "_product"}, 64'(product_o), 64'(exp));
    start_i = 1'b1;
    multiplicand_i = W'($urandom);
    multiplier_i = W'($urandom);
    @(negedge clk_i);  // after e(N+1)
    start_i = 1'b0;
    check({tag, "_done_clear"}, 64'(done_o), 64'd0);
    check({tag, "_idle"}, 64'(busy_o), 64'd0);
    check({tag, "_hold"}, 64'(product_o), 64'(exp));
    last_prod = exp;
  endtask

  initial begin
    int seen_done;
    #1;
    check("rst_product", 64'(product_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    do_op(8'd13, 8'd11, "13x11");
    do_op(8'd255, 8'd255, "255x255");
    do_op(8'd0, 8'd200, "0x200");
    do_op(8'd200, 8'd0, "200x0");
    do_op(8'd6, 8'd7, "6x7");

    // Abort mid-operation: reset on RUN cycle 4.
    start_i = 1'b1;
    multiplicand_i = 8'd100;
    multiplier_i = 8'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk_i);
    check("abort_busy_before", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check("abort_product", 64'(product_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen_done = 0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1 || busy_o === 1'b1) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    last_prod = '0;

    do_op(8'd100, 8'd3, "100x3");
    do_op(8'd6, 8'd7, "6x7b");
    do_op(8'd2, 8'd3, "2x3_b2b");

    for (int k = 0; k < 20; k++) begin
      do_op(W'($urandom), W'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
